// File: rtl/sphere_closest_hit_if.sv
// Ray-in / scene-read / result-out bundle for the closest-hit traversal stage.
// slave is the traversal block; master is the producer, scene memory and consumer side.
interface sphere_closest_hit_if #(
  parameter int IDX_W = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [31:0]      ray_ox, ray_oy, ray_oz;
  logic signed [31:0]      ray_dx, ray_dy, ray_dz;
  logic                    sph_rd;
  logic        [IDX_W-1:0] sph_addr;
  logic signed [31:0]      sph_cx, sph_cy, sph_cz, sph_r;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_hit;
  logic signed [31:0]      out_t;
  logic        [IDX_W-1:0] out_id;

  modport slave (
    input  in_valid, ray_ox, ray_oy, ray_oz, ray_dx, ray_dy, ray_dz,
    input  sph_cx, sph_cy, sph_cz, sph_r, out_ready,
    output in_ready, sph_rd, sph_addr, out_valid, out_hit, out_t, out_id
  );

  modport master (
    output in_valid, ray_ox, ray_oy, ray_oz, ray_dx, ray_dy, ray_dz,
    output sph_cx, sph_cy, sph_cz, sph_r, out_ready,
    input  in_ready, sph_rd, sph_addr, out_valid, out_hit, out_t, out_id
  );
endinterface

// File: rtl/sphere_closest_hit.sv
// Walks NUM_SPHERES scene entries for one ray and returns the nearest accepted hit.
// Contains the combinational ray/sphere intersect unit (unit-length direction assumed).
module ray_sphere_intersect #(
  parameter logic signed [31:0] T_EPS = 32'sh0000_0100
) (
  input  logic signed [31:0] ox, oy, oz,
  input  logic signed [31:0] dx, dy, dz,
  input  logic signed [31:0] cx, cy, cz, r,
  output logic               hit,
  output logic signed [31:0] t
);
  logic signed [67:0] lx, ly, lz, dxw, dyw, dzw, rw;
  logic signed [67:0] b_full, c_full;
  logic signed [47:0] b;
  logic signed [95:0] bw, disc;
  logic        [49:0] rem, trial;
  logic        [47:0] root;
  logic signed [49:0] bx, sx, t0, t1, tsel;

  always_comb begin
    lx  = 68'(cx) - 68'(ox);
    ly  = 68'(cy) - 68'(oy);
    lz  = 68'(cz) - 68'(oz);
    dxw = 68'(dx);
    dyw = 68'(dy);
    dzw = 68'(dz);
    rw  = 68'(r);
    // Q32.32: b = D.L, c = |L|^2 - r^2; with |D| = 1 the roots are b -/+ sqrt(b^2 - c)
    b_full = dxw*lx + dyw*ly + dzw*lz;
    c_full = lx*lx + ly*ly + lz*lz - rw*rw;
    b      = 48'(b_full >>> 16);
    bw     = 96'(b);
    disc   = bw*bw - 96'(c_full);

    // Restoring square root: Q32.32 radicand gives a Q16.16 root
    rem  = '0;
    root = '0;
    for (int i = 47; i >= 0; i--) begin
      rem   = {rem[47:0], disc[2*i +: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[46:0], 1'b1};
      end else begin
        root = {root[46:0], 1'b0};
      end
    end

    bx   = 50'(b);
    sx   = $signed({2'b00, root});
    t0   = bx - sx;
    t1   = bx + sx;
    // Origin on or inside the sphere: the near root is unusable, fall back to the far one
    tsel = (t0 > 50'(T_EPS)) ? t0 : t1;
    hit  = !disc[95] && (tsel < 50'sh0_8000_0000) && (tsel >= -50'sh0_8000_0000);
    t    = 32'(tsel);
  end
endmodule

module sphere_closest_hit #(
  parameter int                 NUM_SPHERES = 4,
  parameter int                 IDX_W       = 2,
  parameter logic signed [31:0] T_EPS       = 32'sh0000_0100,
  parameter logic signed [31:0] T_MAX       = 32'sh7FFF_FFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  sphere_closest_hit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, TEST, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SPHERES - 1);

  state_t                  state, state_nx;
  logic        [IDX_W-1:0] idx, best_id, out_id_q;
  logic                    best_hit, out_hit_q;
  logic signed [31:0]      best_t, out_t_q;
  logic signed [31:0]      ox, oy, oz, dx, dy, dz;
  logic                    isect_hit, accept, last;
  logic signed [31:0]      isect_t;

  ray_sphere_intersect #(.T_EPS(T_EPS)) u_isect (
    .ox(ox), .oy(oy), .oz(oz),
    .dx(dx), .dy(dy), .dz(dz),
    .cx(bus.sph_cx), .cy(bus.sph_cy), .cz(bus.sph_cz), .r(bus.sph_r),
    .hit(isect_hit), .t(isect_t)
  );

  // Strict compare keeps the lower index on equal t
  assign accept = isect_hit && (isect_t > T_EPS) && (isect_t < best_t);
  assign last   = (idx == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = FETCH;
      FETCH:                      state_nx = TEST;
      TEST:                       state_nx = last ? DONE : FETCH;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.sph_rd    = (state == FETCH);
  assign bus.sph_addr  = (state == FETCH) ? idx : '0;
  assign bus.out_valid = (state == DONE);
  assign bus.out_hit   = out_hit_q;
  assign bus.out_t     = out_t_q;
  assign bus.out_id    = out_id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      best_hit  <= 1'b0;
      best_t    <= T_MAX;
      best_id   <= '0;
      out_hit_q <= 1'b0;
      out_t_q   <= T_MAX;
      out_id_q  <= '0;
      {ox, oy, oz, dx, dy, dz} <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ox       <= bus.ray_ox;
          oy       <= bus.ray_oy;
          oz       <= bus.ray_oz;
          dx       <= bus.ray_dx;
          dy       <= bus.ray_dy;
          dz       <= bus.ray_dz;
          idx      <= '0;
          best_hit <= 1'b0;
          best_t   <= T_MAX;
          best_id  <= '0;
        end
        TEST: begin
          if (accept) begin
            best_hit <= 1'b1;
            best_t   <= isect_t;
            best_id  <= idx;
          end
          // Final entry folds this cycle's accept straight into the result
          if (last) begin
            out_hit_q <= accept | best_hit;
            out_t_q   <= accept ? isect_t : best_t;
            out_id_q  <= accept ? idx : best_id;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sphere_closest_hit.sv
// Directed bench: four-entry scene memory model, hand-computed Q16.16 results.
module tb_sphere_closest_hit;
  localparam logic signed [31:0] ONE  = 32'sh0001_0000;
  localparam logic signed [31:0] HALF = 32'sh0000_8000;
  localparam logic signed [31:0] TMAX = 32'sh7FFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic signed [31:0] mem_cx [4], mem_cy [4], mem_cz [4], mem_r [4];

  sphere_closest_hit_if #(.IDX_W(2)) bus ();
  sphere_closest_hit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Registered scene read: data appears the cycle after sph_rd
  always @(posedge clk) begin
    if (bus.sph_rd) begin
      bus.sph_cx <= mem_cx[bus.sph_addr];
      bus.sph_cy <= mem_cy[bus.sph_addr];
      bus.sph_cz <= mem_cz[bus.sph_addr];
      bus.sph_r  <= mem_r[bus.sph_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_sph(input int i, input logic signed [31:0] cx, cy, cz, r);
    mem_cx[i] = cx; mem_cy[i] = cy; mem_cz[i] = cz; mem_r[i] = r;
  endtask

  task automatic scene_a();
    set_sph(0, 0, 0, 5*ONE, ONE);
    set_sph(1, 0, 0, 3*ONE, HALF);
    set_sph(2, 10*ONE, 10*ONE, 10*ONE, ONE);
    set_sph(3, 10*ONE, 10*ONE, 10*ONE, ONE);
  endtask

  // Drive a ray and return just after its accept edge
  task automatic send_ray(input string tag, input logic signed [31:0] ox, oy, oz, dx, dy, dz);
    int k = 0;
    @(negedge clk);
    bus.ray_ox = ox; bus.ray_oy = oy; bus.ray_oz = oz;
    bus.ray_dx = dx; bus.ray_dy = dy; bus.ray_dz = dz;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_res(input string tag, input logic hit, input logic [31:0] t, input logic [1:0] id);
    chk({tag, "_hit"}, bus.out_hit, hit);
    chk({tag, "_t"},   bus.out_t,   t);
    chk({tag, "_id"},  bus.out_id,  id);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 chk({tag, "_vld_clr"}, bus.out_valid, 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held_t;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.ray_ox = '0; bus.ray_oy = '0; bus.ray_oz = '0;
    bus.ray_dx = '0; bus.ray_dy = '0; bus.ray_dz = '0;
    scene_a();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    bus.out_valid, 0);
    chk("rst_hit",      bus.out_hit,   0);
    chk("rst_t",        bus.out_t,     TMAX);
    chk("rst_id",       bus.out_id,    0);
    chk("rst_rd",       bus.sph_rd,    0);
    chk("rst_addr",     bus.sph_addr,  0);
    chk("rst_in_ready", bus.in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;

    // Nearest of two on-axis spheres
    send_ray("axis", 0, 0, 0, 0, 0, ONE);
    #0 chk("axis_busy", bus.in_ready, 0);
    wait_out("axis", 8);
    check_res("axis", 1'b1, 32'h0002_8000, 2'd1);
    take("axis");

    send_ray("miss", 0, 0, 0, ONE, 0, 0);
    wait_out("miss", 8);
    check_res("miss", 1'b0, TMAX, 2'd0);
    take("miss");

    // Origin on s0's surface; s1 lies behind the ray
    send_ray("inside", 0, 0, 4*ONE, 0, 0, ONE);
    wait_out("inside", 8);
    check_res("inside", 1'b1, 32'h0002_0000, 2'd0);
    take("inside");

    // Equal t on s0 and s2 keeps the lower index
    set_sph(2, 0, 0, 5*ONE, ONE);
    set_sph(1, 10*ONE, 0, 3*ONE, HALF);
    send_ray("tie", 0, 0, 0, 0, 0, ONE);
    wait_out("tie", 8);
    check_res("tie", 1'b1, 32'h0004_0000, 2'd0);
    take("tie");
    scene_a();

    // Backpressure with a pending ray waiting at the input
    send_ray("bp", 0, 0, 0, 0, 0, ONE);
    wait_out("bp", 8);
    held_t = bus.out_t;
    @(negedge clk);
    bus.ray_dx = ONE; bus.ray_dz = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid",    bus.out_valid, 1);
      chk("bp_t",        bus.out_t,     32'h0002_8000);
      chk("bp_id",       bus.out_id,    1);
      chk("bp_in_ready", bus.in_ready,  0);
      chk("bp_rd",       bus.sph_rd,    0);
    end
    chk("bp_t_held", bus.out_t, held_t);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid",    bus.out_valid, 0);
    chk("bp_hs_in_ready", bus.in_ready,  1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_acc_in_ready", bus.in_ready, 0);
    chk("bp_acc_rd",       bus.sph_rd,   1);
    bus.in_valid = 1'b0;
    wait_out("bp2", 8);
    check_res("bp2", 1'b0, TMAX, 2'd0);
    take("bp2");

    // Reset while testing sphere 2
    send_ray("rst_mid", 0, 0, 0, 0, 0, ONE);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_rd",   bus.sph_rd,   1);
    chk("rst_mid_addr", bus.sph_addr, 2);
    @(posedge clk);
    #1 chk("rst_mid_test_rd", bus.sph_rd, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_rd0",   bus.sph_rd,    0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_mid_in_ready", bus.in_ready, 1);
    send_ray("fresh", 0, 0, 0, 0, 0, ONE);
    wait_out("fresh", 8);
    check_res("fresh", 1'b1, 32'h0002_8000, 2'd1);
    take("fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
